// File: rtl/spi_regfile_slave_if.sv
// spi_regfile_slave_if
// Bundles the SPI pins, the host-side parallel register port and the
// SPI write-notification / status outputs of spi_regfile_slave.
//   SPI     : SCK, SS (active low), MOSI, CPOL, CPHA -> slave; MISO, miso_oe <- slave
//   Host    : host_addr, host_we, host_wdata -> slave; host_rdata <- slave
//   Status  : wr_valid, wr_addr, wr_data, frame_abort, addr_err <- slave
// The master modport is the side that drives the pins and the host port.
interface spi_regfile_slave_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 32
);
    logic                     SCK;
    logic                     SS;
    logic                     MOSI;
    logic                     CPOL;
    logic                     CPHA;
    logic                     MISO;
    logic                     miso_oe;
    logic [ADDRESS_WIDTH-1:0] host_addr;
    logic                     host_we;
    logic [DATA_WIDTH-1:0]    host_wdata;
    logic [DATA_WIDTH-1:0]    host_rdata;
    logic                     wr_valid;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     frame_abort;
    logic                     addr_err;

    modport master (
        output SCK, SS, MOSI, CPOL, CPHA, host_addr, host_we, host_wdata,
        input  MISO, miso_oe, host_rdata, wr_valid, wr_addr, wr_data,
               frame_abort, addr_err
    );

    modport slave (
        input  SCK, SS, MOSI, CPOL, CPHA, host_addr, host_we, host_wdata,
        output MISO, miso_oe, host_rdata, wr_valid, wr_addr, wr_data,
               frame_abort, addr_err
    );
endinterface

// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave
// SPI register-file slave running entirely on clk. SCK, SS and MOSI are
// oversampled through 2-flop synchronisers; all four CPOL/CPHA modes are
// supported. Frame = RW (1=read) + address + data, MSB first.
// Ports:
//   clk   - system clock, all state changes on its rising edge
//   reset - asynchronous, active-high, clears all state and the register file
//   bus   - spi_regfile_slave_if.slave: SPI pins, host port, SPI write
//           notification (wr_valid/wr_addr/wr_data), frame_abort, addr_err
module spi_regfile_slave #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int REG_DEPTH     = 16
) (
    input  logic               clk,
    input  logic               reset,
    spi_regfile_slave_if.slave bus
);
    localparam int N     = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0]       CNT_N         = CNT_W'(N);
    localparam logic [CNT_W-1:0]       CNT_LAST_ADDR = CNT_W'(ADDRESS_WIDTH);
    localparam logic [CNT_W-1:0]       CNT_LAST_DATA = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE       = CNT_W'(1);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_L       = (ADDRESS_WIDTH + 1)'(REG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [1:0]               sck_sync_r;
    logic [1:0]               ss_sync_r;
    logic [1:0]               mosi_sync_r;
    logic                     sck_prev_r;
    logic                     ss_prev_r;

    state_t                   state_r;
    logic                     cpol_r;
    logic                     cpha_r;
    logic [CNT_W-1:0]         bit_cnt_r;
    logic [ADDRESS_WIDTH-1:0] cmd_r;
    logic [DATA_WIDTH-2:0]    data_r;
    logic [DATA_WIDTH-1:0]    shift_out_r;
    logic                     rw_r;
    logic                     in_range_r;
    logic                     miso_r;
    logic                     miso_oe_r;
    logic                     wr_valid_r;
    logic [ADDRESS_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0]    wr_data_r;
    logic                     frame_abort_r;
    logic                     addr_err_r;
    logic [DATA_WIDTH-1:0]    host_rdata_r;
    logic [DATA_WIDTH-1:0]    regfile_r [REG_DEPTH];

    logic                     sck_s, ss_s, mosi_s;
    logic                     sck_rise_s, sck_fall_s, lead_s, trail_s;
    logic                     sample_s, shift_s;
    logic [ADDRESS_WIDTH:0]   cmd_next_s;
    logic [ADDRESS_WIDTH-1:0] cmd_addr_s;
    logic [DATA_WIDTH-1:0]    data_next_s;
    logic                     cmd_in_range_s;
    logic                     host_in_range_s;
    logic                     host_wr_ok_s;

    assign sck_s  = sck_sync_r[1];
    assign ss_s   = ss_sync_r[1];
    assign mosi_s = mosi_sync_r[1];

    // Two-flop synchronisers for the asynchronous SPI pins plus edge history.
    // SS history resets low so a frame only starts on a fresh high-to-low SS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_r  <= 2'b00;
            ss_sync_r   <= 2'b00;
            mosi_sync_r <= 2'b00;
            sck_prev_r  <= 1'b0;
            ss_prev_r   <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[0], bus.SCK};
            ss_sync_r   <= {ss_sync_r[0], bus.SS};
            mosi_sync_r <= {mosi_sync_r[0], bus.MOSI};
            sck_prev_r  <= sck_s;
            ss_prev_r   <= ss_s;
        end
    end

    // Edge classification for the captured mode and next-value helpers.
    always_comb begin
        sck_rise_s      = sck_s & ~sck_prev_r;
        sck_fall_s      = ~sck_s & sck_prev_r;
        lead_s          = cpol_r ? sck_fall_s : sck_rise_s;
        trail_s         = cpol_r ? sck_rise_s : sck_fall_s;
        sample_s        = cpha_r ? trail_s : lead_s;
        shift_s         = cpha_r ? lead_s : trail_s;
        cmd_next_s      = {cmd_r, mosi_s};
        cmd_addr_s      = cmd_next_s[ADDRESS_WIDTH-1:0];
        data_next_s     = {data_r, mosi_s};
        cmd_in_range_s  = ({1'b0, cmd_addr_s} < DEPTH_L);
        host_in_range_s = ({1'b0, bus.host_addr} < DEPTH_L);
        // A same-clock SPI commit to the same address takes priority.
        host_wr_ok_s    = bus.host_we & host_in_range_s &
                          ~(wr_valid_r & (wr_addr_r == bus.host_addr));
    end

    // Frame state machine: command/data shifting, MISO drive, commit and abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            bit_cnt_r     <= {CNT_W{1'b0}};
            cmd_r         <= {ADDRESS_WIDTH{1'b0}};
            data_r        <= {(DATA_WIDTH-1){1'b0}};
            shift_out_r   <= {DATA_WIDTH{1'b0}};
            rw_r          <= 1'b0;
            in_range_r    <= 1'b0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            wr_valid_r    <= 1'b0;
            wr_addr_r     <= {ADDRESS_WIDTH{1'b0}};
            wr_data_r     <= {DATA_WIDTH{1'b0}};
            frame_abort_r <= 1'b0;
            addr_err_r    <= 1'b0;
        end else begin
            wr_valid_r    <= 1'b0;
            frame_abort_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    miso_r    <= 1'b0;
                    miso_oe_r <= 1'b0;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    if (ss_prev_r && !ss_s) begin
                        cpol_r    <= bus.CPOL;
                        cpha_r    <= bus.CPHA;
                        miso_oe_r <= 1'b1;
                        state_r   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (ss_s) begin
                        frame_abort_r <= 1'b1;
                        miso_r        <= 1'b0;
                        miso_oe_r     <= 1'b0;
                        bit_cnt_r     <= {CNT_W{1'b0}};
                        state_r       <= ST_IDLE;
                    end else if (sample_s) begin
                        cmd_r     <= cmd_next_s[ADDRESS_WIDTH-1:0];
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        if (bit_cnt_r == CNT_LAST_ADDR) begin
                            rw_r       <= cmd_next_s[ADDRESS_WIDTH];
                            wr_addr_r  <= wr_addr_r;
                            in_range_r <= cmd_in_range_s;
                            cmd_r      <= cmd_addr_s;
                            state_r    <= ST_DATA;
                            shift_out_r <= cmd_in_range_s ? regfile_r[cmd_addr_s]
                                                          : {DATA_WIDTH{1'b0}};
                            if (!cmd_in_range_s) begin
                                addr_err_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (ss_s) begin
                        // Raising SS after the full frame is a normal end.
                        frame_abort_r <= (bit_cnt_r != CNT_N);
                        miso_r        <= 1'b0;
                        miso_oe_r     <= 1'b0;
                        bit_cnt_r     <= {CNT_W{1'b0}};
                        state_r       <= ST_IDLE;
                    end else begin
                        if (shift_s) begin
                            if (rw_r && (bit_cnt_r != CNT_N)) begin
                                miso_r      <= shift_out_r[DATA_WIDTH-1];
                                shift_out_r <= {shift_out_r[DATA_WIDTH-2:0], 1'b0};
                            end else begin
                                miso_r <= 1'b0;
                            end
                        end
                        if (sample_s && (bit_cnt_r != CNT_N)) begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            data_r    <= data_next_s[DATA_WIDTH-2:0];
                            if (!rw_r && in_range_r && (bit_cnt_r == CNT_LAST_DATA)) begin
                                wr_valid_r <= 1'b1;
                                wr_addr_r  <= cmd_r;
                                wr_data_r  <= data_next_s;
                            end
                        end
                    end
                end
                default: begin
                    miso_r    <= 1'b0;
                    miso_oe_r <= 1'b0;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: SPI commit lands in the wr_valid clock, host port writes
    // when not colliding, host read is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regfile_r[i] <= {DATA_WIDTH{1'b0}};
            end
            host_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (wr_valid_r) begin
                regfile_r[wr_addr_r] <= wr_data_r;
            end
            if (host_wr_ok_s) begin
                regfile_r[bus.host_addr] <= bus.host_wdata;
            end
            host_rdata_r <= host_in_range_s ? regfile_r[bus.host_addr]
                                            : {DATA_WIDTH{1'b0}};
        end
    end

    assign bus.MISO        = miso_r;
    assign bus.miso_oe     = miso_oe_r;
    assign bus.host_rdata  = host_rdata_r;
    assign bus.wr_valid    = wr_valid_r;
    assign bus.wr_addr     = wr_addr_r;
    assign bus.wr_data     = wr_data_r;
    assign bus.frame_abort = frame_abort_r;
    assign bus.addr_err    = addr_err_r;
endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed self-checking bench for spi_regfile_slave (REG_DEPTH=12 so that
// addresses 12..15 are out of range). SCK half period is 4 clk.
module tb_spi_regfile_slave;
    localparam int H = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   abort_cnt;
    int   snap_wr;
    int   snap_ab;
    logic [31:0] rx;
    logic [31:0] rd;
    logic        seen;

    spi_regfile_slave_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(32)) bus ();

    spi_regfile_slave #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(4),
        .REG_DEPTH(12)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high clocks of the pulse outputs, sampled away from the active edge.
    initial begin
        wr_cnt    = 0;
        abort_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.wr_valid === 1'b1) wr_cnt++;
            if (bus.frame_abort === 1'b1) abort_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.host_addr = a;
        @(negedge clk);
        d = bus.host_rdata;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    // SPI master: sends nbits of {rw, addr, data}; collects MISO on its sample edges.
    task automatic spi_frame(input logic rw, input logic [3:0] a, input logic [31:0] d,
                             input logic cpol, input logic cpha, input int nbits,
                             input logic end_ss, output logic [31:0] r);
        logic [36:0] f;
        f = {rw, a, d};
        r = 32'h0;
        @(negedge clk);
        bus.CPOL = cpol;
        bus.CPHA = cpha;
        bus.SCK  = cpol;
        bus.MOSI = 1'b0;
        wait_clks(6);
        bus.SS = 1'b0;
        wait_clks(8);
        check("miso_oe_in_frame", {31'd0, bus.miso_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (cpha == 1'b0) begin
                bus.MOSI = f[36-i];
                wait_clks(H);
                bus.SCK = ~cpol;
                if (i >= 5) r = {r[30:0], bus.MISO};
                wait_clks(H);
                bus.SCK = cpol;
            end else begin
                bus.SCK  = ~cpol;
                bus.MOSI = f[36-i];
                wait_clks(H);
                bus.SCK = cpol;
                if (i >= 5) r = {r[30:0], bus.MISO};
                wait_clks(H);
            end
        end
        wait_clks(H);
        if (end_ss) begin
            bus.SS = 1'b1;
            wait_clks(8);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        seen   = 1'b0;
        reset  = 1'b1;
        bus.SCK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0;
        bus.CPOL = 1'b0; bus.CPHA = 1'b0;
        bus.host_addr = 4'd0; bus.host_we = 1'b0; bus.host_wdata = 32'd0;
        wait_clks(3);
        check("rst_miso",        {31'd0, bus.MISO},        32'd0);
        check("rst_miso_oe",     {31'd0, bus.miso_oe},     32'd0);
        check("rst_host_rdata",  bus.host_rdata,           32'd0);
        check("rst_wr_valid",    {31'd0, bus.wr_valid},    32'd0);
        check("rst_wr_addr",     {28'd0, bus.wr_addr},     32'd0);
        check("rst_wr_data",     bus.wr_data,              32'd0);
        check("rst_frame_abort", {31'd0, bus.frame_abort}, 32'd0);
        check("rst_addr_err",    {31'd0, bus.addr_err},    32'd0);
        reset = 1'b0;
        wait_clks(4);

        // Mode 0 write addr 3.
        snap_wr = wr_cnt; snap_ab = abort_cnt;
        spi_frame(1'b0, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 37, 1'b1, rx);
        check("w3_wr_valid_pulses", wr_cnt - snap_wr, 32'd1);
        check("w3_no_abort", abort_cnt - snap_ab, 32'd0);
        check("w3_wr_addr", {28'd0, bus.wr_addr}, 32'd3);
        check("w3_wr_data", bus.wr_data, 32'hDEADBEEF);
        check("w3_miso_oe_idle", {31'd0, bus.miso_oe}, 32'd0);
        host_read(4'd3, rd);
        check("w3_host_read", rd, 32'hDEADBEEF);

        // Host write addr 5, SPI read in all four modes.
        host_write(4'd5, 32'h12345678);
        host_read(4'd5, rd);
        check("h5_host_read", rd, 32'h12345678);
        for (int m = 0; m < 4; m++) begin
            logic [1:0] md;
            md = m[1:0];
            snap_wr = wr_cnt;
            spi_frame(1'b1, 4'd5, 32'h0, md[1], md[0], 37, 1'b1, rx);
            check($sformatf("read5_mode%0d", m), rx, 32'h12345678);
            check($sformatf("read5_mode%0d_no_wr", m), wr_cnt - snap_wr, 32'd0);
        end

        // Abort after 20 bits of a write to addr 2.
        snap_wr = wr_cnt; snap_ab = abort_cnt;
        spi_frame(1'b0, 4'd2, 32'hCAFEF00D, 1'b0, 1'b0, 20, 1'b1, rx);
        check("abort_pulses", abort_cnt - snap_ab, 32'd1);
        check("abort_no_wr", wr_cnt - snap_wr, 32'd0);
        host_read(4'd2, rd);
        check("abort_reg2_unchanged", rd, 32'd0);
        snap_wr = wr_cnt;
        spi_frame(1'b0, 4'd2, 32'h0BADF00D, 1'b1, 1'b1, 37, 1'b1, rx);
        check("after_abort_wr", wr_cnt - snap_wr, 32'd1);
        host_read(4'd2, rd);
        check("after_abort_reg2", rd, 32'h0BADF00D);
        check("addr_err_clear", {31'd0, bus.addr_err}, 32'd0);

        // Out-of-range address 14 with REG_DEPTH=12.
        snap_wr = wr_cnt;
        spi_frame(1'b0, 4'd14, 32'hFFFFFFFF, 1'b0, 1'b0, 37, 1'b1, rx);
        check("oor_no_wr", wr_cnt - snap_wr, 32'd0);
        check("oor_addr_err_w", {31'd0, bus.addr_err}, 32'd1);
        spi_frame(1'b1, 4'd14, 32'h0, 1'b0, 1'b0, 37, 1'b1, rx);
        check("oor_read_zero", rx, 32'd0);
        check("oor_addr_err_sticky", {31'd0, bus.addr_err}, 32'd1);
        host_read(4'd14, rd);
        check("oor_host_read", rd, 32'd0);

        // Same-clock SPI commit and host write to addr 7.
        snap_wr = wr_cnt;
        fork
            spi_frame(1'b0, 4'd7, 32'hAAAA0000, 1'b0, 1'b0, 37, 1'b1, rx);
            begin
                for (int k = 0; k < 1000 && !seen; k++) begin
                    @(negedge clk);
                    if (bus.wr_valid === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    bus.host_addr  = 4'd7;
                    bus.host_wdata = 32'h5555FFFF;
                    bus.host_we    = 1'b1;
                    @(negedge clk);
                    bus.host_we    = 1'b0;
                end
            end
        join
        check("coll_commit_seen", {31'd0, seen}, 32'd1);
        check("coll_wr", wr_cnt - snap_wr, 32'd1);
        host_read(4'd7, rd);
        check("coll_spi_wins", rd, 32'hAAAA0000);

        // Reset pulsed at bit 30 of a write to addr 1.
        snap_wr = wr_cnt;
        spi_frame(1'b0, 4'd1, 32'h13579BDF, 1'b0, 1'b0, 30, 1'b0, rx);
        reset = 1'b1;
        wait_clks(2);
        check("mrst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("mrst_addr_err", {31'd0, bus.addr_err}, 32'd0);
        check("mrst_wr_addr", {28'd0, bus.wr_addr}, 32'd0);
        check("mrst_wr_data", bus.wr_data, 32'd0);
        check("mrst_host_rdata", bus.host_rdata, 32'd0);
        reset = 1'b0;
        wait_clks(10);
        check("mrst_stays_idle", {31'd0, bus.miso_oe}, 32'd0);
        check("mrst_no_wr", wr_cnt - snap_wr, 32'd0);
        bus.SS = 1'b1;
        wait_clks(6);
        host_read(4'd1, rd);
        check("mrst_reg1_zero", rd, 32'd0);
        host_read(4'd3, rd);
        check("mrst_reg3_cleared", rd, 32'd0);
        snap_wr = wr_cnt;
        spi_frame(1'b0, 4'd1, 32'h600DCAFE, 1'b0, 1'b1, 37, 1'b1, rx);
        check("mrst_next_frame_wr", wr_cnt - snap_wr, 32'd1);
        host_read(4'd1, rd);
        check("mrst_next_frame_reg1", rd, 32'h600DCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
